fifo_rd_stream: RTL
===================

// Module: fifo_rd_stream
// PURPOSE
//  Downstream consumer of the 8-bit single-clock FIFO (fifo_top, normal/non-show-ahead mode: q valid 1 cycle after rdreq).
//  Drains the FIFO and converts it to a valid/ready stream, framed into fixed-length packets (m_last on final beat).
//  Internal 4-entry skid buffer with registered credit gives full throughput with no m_ready -> fifo_rdreq comb path.
// PARAMETERS
//  DATA_W   8   width of FIFO word and stream data
//  PKT_LEN  16  beats per packet, legal 1..256; m_last on beat PKT_LEN-1
// PORTS
//  clock       in   1       single clock, all logic on rising edge
//  reset_n     in   1       asynchronous, active-low reset
//  enable      in   1       level; 1 = drain FIFO, 0 = stop issuing reads
//  fifo_q      in   DATA_W  FIFO read data (valid the cycle after fifo_rdreq)
//  fifo_empty  in   1       FIFO empty flag
//  fifo_rdreq  out  1       FIFO read request
//  m_data      out  DATA_W  stream data (head of skid buffer)
//  m_valid     out  1       stream valid
//  m_last      out  1       final beat of packet
//  m_ready     in   1       stream ready
//  m_csum      out  DATA_W  packet checksum, meaningful with m_last (see CONFIGURATION)
//  pkt_count   out  16      completed packets, wraps 0xFFFF -> 0
//  busy        out  1       state != IDLE
// BEHAVIOUR
//  - Reset (async assert, sync release): state=IDLE, occ=0, inflight=0, beat_cnt=0, pkt_count=0, csum=0;
//    all outputs 0. Read data in flight at reset is discarded; FIFO aclr must share reset_n.
//  - fifo_rdreq = (state==RUN) & !fifo_empty & (occ + inflight < 4); occ/inflight are registers only.
//  - inflight <= fifo_rdreq (0/1). When inflight==1, fifo_q is written to skid tail that cycle.
//  - Handshake: beat transfers when m_valid & m_ready. m_valid = (occ != 0). m_data/m_last stable while
//    m_valid & !m_ready. Simultaneous write and pop: occ unchanged, both take effect.
//  - occ never exceeds 4: credit counts inflight, so a returning word always has a slot.
//  - Latency: fifo_rdreq at cycle N -> word in buffer at N+1 -> m_valid earliest at N+2 (empty buffer).
//  - Throughput: 1 beat/cycle sustained with m_ready=1 and FIFO non-empty.
//  - Framing: beat_cnt counts transferred beats 0..PKT_LEN-1; m_last = m_valid & (beat_cnt==PKT_LEN-1).
//    On last-beat transfer: beat_cnt<=0, pkt_count<=pkt_count+1 (mod 2^16). PKT_LEN=1: every beat last.
//  - FSM: IDLE -> RUN when enable=1.
//    RUN -> DRAIN when enable=0; no further reads.
//    DRAIN -> IDLE when inflight==0 & occ==0.
//    DRAIN -> RUN when enable=1 again. Buffered and in-flight words are always delivered, never dropped.
//    beat_cnt is not reset by enable toggling; partial packets resume.
//  - fifo_empty with inflight: reads stop; no underflow request is ever issued (rdreq gated by !fifo_empty).
// CONFIGURATION
//  - STREAM_CSUM_EN defined: csum accumulates transferred bytes mod 2^DATA_W.
//    m_csum = csum + m_data (combinational) on the last beat; csum<=0 after the last beat transfers.
//  - Not defined: m_csum tied to 0, no accumulator logic.
// STRUCTURE
//  - Package fifo_rd_pkg: state encoding (IDLE=2'd0, RUN=2'd1, DRAIN=2'd2) and SKID_DEPTH=4.
//  - Sub-module fifo_rd_skid: 4-entry register FIFO (2-bit ptrs, 3-bit occ), push/pop/head/occ.
//  - Top holds FSM, credit/inflight, framing counters, optional checksum.
// TESTING (bench pairs this block with fifo_top)
//  1. Preload 32 bytes 0x00..0x1F, enable=1, m_ready=1 -> 32 beats in order, 1/cycle after 2-cycle startup,
//     m_last on 0x0F and 0x1F, pkt_count=2.
//  2. m_ready toggles 1/0 each cycle, 16 bytes -> no loss/duplication, occ<=4, data held stable while stalled.
//  3. Drop enable mid-stream with 3 buffered + 1 in flight -> no rdreq after drop, 4 beats delivered,
//     busy falls when occ=0 and inflight=0; re-enable resumes at beat_cnt 4.
//  4. FIFO empty after 5 bytes -> fifo_rdreq never high while fifo_empty=1; no m_last; pkt_count stays 0.
//  5. STREAM_CSUM_EN, 16 bytes of 0x11 -> m_csum=0x10 on last beat; next packet of 0x01 -> 0x10.
//  6. Assert reset_n=0 mid-packet -> all outputs 0 immediately; after release, fresh packet starts at beat 0.

Source files
------------

// File: rtl/fifo_rd_pkg.sv
// Shared definitions for the FIFO read-side stream adapter:
// FSM state encoding and skid buffer depth.
package fifo_rd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam int SKID_DEPTH = 4;

endpackage

// File: rtl/fifo_rd_skid.sv
// Four-entry register FIFO used as the skid buffer between the FIFO read
// port and the valid/ready stream. The caller guarantees no push when full
// and no pop when empty. The head is always visible.
module fifo_rd_skid
    import fifo_rd_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic [2:0]        occ
);

    logic [DATA_W-1:0] mem [SKID_DEPTH];
    logic [1:0]        wr_ptr;
    logic [1:0]        rd_ptr;
    logic [2:0]        occ_r;

    // Storage is cleared on reset so the head reads 0 while the buffer is empty after reset
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SKID_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; a push and a pop in the same cycle leave occ unchanged
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
            occ_r  <= 3'd0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 2'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            case ({push, pop})
                2'b10:   occ_r <= occ_r + 3'd1;
                2'b01:   occ_r <= occ_r - 3'd1;
                default: occ_r <= occ_r;
            endcase
        end
    end

    assign head = mem[rd_ptr];
    assign occ  = occ_r;

endmodule

// File: rtl/fifo_rd_stream.sv
// Drains a non-show-ahead FIFO into a valid/ready stream framed into
// PKT_LEN-beat packets. Read requests depend only on registered credit
// (occ + inflight), so m_ready has no combinational path to fifo_rdreq.
// Optional per-packet checksum enabled by defining STREAM_CSUM_EN.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  ST_IDLE  | stopped, nothing buffered or in flight
//  ST_RUN   | issuing FIFO reads while credit allows
//  ST_DRAIN | no new reads; delivering buffered and in-flight words
module fifo_rd_stream
    import fifo_rd_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int PKT_LEN = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              enable,
    input  logic [DATA_W-1:0] fifo_q,
    input  logic              fifo_empty,
    output logic              fifo_rdreq,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    output logic              m_last,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_csum,
    output logic [15:0]       pkt_count,
    output logic              busy
);

    localparam logic [7:0] LAST_BEAT = 8'(PKT_LEN - 1);
    localparam logic [3:0] DEPTH     = 4'(SKID_DEPTH);

    state_t            state;
    logic              inflight;
    logic [2:0]        occ;
    logic [3:0]        credit_used;
    logic [DATA_W-1:0] head;
    logic [7:0]        beat_cnt;
    logic [15:0]       pkt_count_r;
    logic              pop;

    fifo_rd_skid #(
        .DATA_W (DATA_W)
    ) u_skid (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (inflight),
        .push_data (fifo_q),
        .pop       (pop),
        .head      (head),
        .occ       (occ)
    );

    // Counting the in-flight word against the buffer guarantees a slot when it lands
    assign credit_used = {1'b0, occ} + {3'b000, inflight};
    assign fifo_rdreq  = (state == ST_RUN) & ~fifo_empty & (credit_used < DEPTH);

    assign m_valid   = (occ != 3'd0);
    assign m_data    = head;
    assign m_last    = m_valid & (beat_cnt == LAST_BEAT);
    assign pop       = m_valid & m_ready;
    assign pkt_count = pkt_count_r;
    assign busy      = (state != ST_IDLE);

    // Run/drain sequencing; drain only finishes once every accepted word has been delivered
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (enable) state <= ST_RUN;
                end
                ST_RUN: begin
                    if (!enable) state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (enable) begin
                        state <= ST_RUN;
                    end else if (!inflight && (occ == 3'd0)) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // A read issued this cycle returns data next cycle; a read pending at reset is dropped
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            inflight <= 1'b0;
        end else begin
            inflight <= fifo_rdreq;
        end
    end

    // Beat position within the packet survives enable toggling so partial packets resume
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            beat_cnt    <= 8'd0;
            pkt_count_r <= 16'd0;
        end else if (pop) begin
            if (m_last) begin
                beat_cnt    <= 8'd0;
                pkt_count_r <= pkt_count_r + 16'd1;
            end else begin
                beat_cnt <= beat_cnt + 8'd1;
            end
        end
    end

`ifdef STREAM_CSUM_EN
    logic [DATA_W-1:0] csum;

    // Running byte sum of the packet so far; the last beat is folded in combinationally
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            csum <= '0;
        end else if (pop) begin
            if (m_last) begin
                csum <= '0;
            end else begin
                csum <= csum + m_data;
            end
        end
    end

    assign m_csum = m_last ? (csum + m_data) : '0;
`else
    assign m_csum = '0;
`endif

endmodule
